// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: FSM state encodings and
// the clock and SCLK defaults that spi_master also assumes.
package spi_pkg;

  localparam int unsigned DEFAULT_SPEED = 1_000_000;
  localparam int unsigned CLK_HZ        = 100_000_000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_LOW  = ST_WAIT_LOW,
    WAIT_HIGH = ST_WAIT_HIGH,
    RESP      = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/spi_req_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, returned both one-hot and as an index.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one spi_master between NREQ requesters, one byte per grant.
// Optional watchdog on the cs handshake: define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int SPEED_W = 28,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_chip,
  input  logic [SPEED_W*NREQ-1:0] req_speed,
  input  logic [NREQ-1:0]         req_cpol,
  input  logic [NREQ-1:0]         req_cpha,
  output logic [NREQ-1:0]         resp_valid,
  output logic [7:0]              resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    pulse1,
  output logic                    pulse2,
  output logic [SPEED_W-1:0]      speed,
  output logic [7:0]              data2send,
  output logic                    cpol,
  output logic                    cpha,
  input  logic                    cs1,
  input  logic                    cs2,
  input  logic [7:0]              data_received
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, owner, gidx;
  logic [NREQ-1:0]  gnt;
  logic             gany;
  logic             chip_r;
  logic             tgt_cs, done_ok, timeout, abort, waiting;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gidx),
    .any   (gany)
  );

  assign tgt_cs  = chip_r ? cs2 : cs1;
  assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign done_ok = (state == WAIT_HIGH) && cs1 && cs2;
  assign abort   = timeout && !done_ok;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_r;

  assign timeout  = waiting && (wd_cnt == WD_LAST);
  assign resp_err = (state == RESP) && err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      wd_cnt <= waiting ? wd_cnt + 16'd1 : '0;
      if (state == IDLE && gany) err_r <= 1'b0;
      else if (abort)            err_r <= 1'b1;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{WD_LAST, waiting};
  assign timeout   = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: if (gany) begin
        req_ready = gnt;
        state_nxt = LAUNCH;
      end
      LAUNCH:    state_nxt = WAIT_LOW;
      WAIT_LOW:  if (timeout) state_nxt = RESP;
                 else if (!tgt_cs) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (done_ok || timeout) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant stage: master-facing config is captured here and held until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      chip_r    <= 1'b0;
      speed     <= SPEED_W'(DEFAULT_SPEED);
      data2send <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gany) begin
        owner     <= gidx;
        rr_ptr    <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
        chip_r    <= req_chip[gidx];
        speed     <= req_speed[gidx*SPEED_W +: SPEED_W];
        data2send <= req_data[gidx*8 +: 8];
        cpol      <= req_cpol[gidx];
        cpha      <= req_cpha[gidx];
      end
      if (done_ok)    resp_data <= data_received;
      else if (abort) resp_data <= 8'hFF;
    end
  end

  assign pulse1     = (state == LAUNCH) && !chip_r;
  assign pulse2     = (state == LAUNCH) && chip_r;
  assign busy       = (state != IDLE) || gany;
  assign resp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter with a behavioural spi_master/loopback
// model driving cs1/cs2 and a transaction-level round-robin reference.
`timescale 1ns/1ps
module tb_spi_req_arbiter;

  localparam int NREQ    = 3;
  localparam int SPEED_W = 28;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid, req_ready, req_chip, req_cpol, req_cpha, resp_valid;
  logic [8*NREQ-1:0]       req_data;
  logic [SPEED_W*NREQ-1:0] req_speed;
  logic [7:0]              resp_data, data2send;
  logic                    resp_err, busy, pulse1, pulse2, cpol, cpha;
  logic [SPEED_W-1:0]      speed;
  logic                    cs1 = 1'b1, cs2 = 1'b1;
  logic [7:0]              data_received = 8'h00;

  spi_req_arbiter #(.NREQ(NREQ), .SPEED_W(SPEED_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_chip(req_chip), .req_speed(req_speed),
    .req_cpol(req_cpol), .req_cpha(req_cpha), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .pulse1(pulse1), .pulse2(pulse2), .speed(speed), .data2send(data2send),
    .cpol(cpol), .cpha(cpha), .cs1(cs1), .cs2(cs2), .data_received(data_received)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, rise_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural master: cs low two cycles after a start pulse, random length,
  // then cs high with the looped-back byte on data_received.
  int         m_phase = 0, m_cnt = 0;
  logic       m_chip;
  logic [7:0] m_byte;
  bit         stuck = 0;
  always @(negedge clk) begin
    if (reset) begin
      cs1 = 1'b1; cs2 = 1'b1; m_phase = 0;
    end else begin
      check_eq("pulse_excl", pulse1 & pulse2, 0);
      case (m_phase)
        0: if ((pulse1 || pulse2) && !stuck) begin
          m_chip = pulse2; m_byte = data2send; m_phase = 1;
        end
        1: begin
          if (m_chip) cs2 = 1'b0; else cs1 = 1'b0;
          data_received = 8'($urandom);
          m_cnt = $urandom_range(3, 9);
          m_phase = 2;
        end
        default: if (m_cnt == 0) begin
          cs1 = 1'b1; cs2 = 1'b1; data_received = m_byte; rise_cyc = cyc; m_phase = 0;
        end else m_cnt--;
      endcase
    end
  end

  // Requester side stimulus and reference state
  logic [NREQ-1:0]    pend;
  logic [7:0]         r_data [NREQ];
  logic [SPEED_W-1:0] r_speed[NREQ];
  logic [NREQ-1:0]    r_chip, r_cpol, r_cpha;
  int                 ptr = 0;

  task automatic drive();
    req_valid = pend;
    req_chip  = r_chip;
    req_cpol  = r_cpol;
    req_cpha  = r_cpha;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*8 +: 8]              = r_data[i];
      req_speed[i*SPEED_W +: SPEED_W] = r_speed[i];
    end
  endtask

  task automatic new_cfg(input int i);
    r_data[i]  = 8'($urandom);
    r_speed[i] = SPEED_W'($urandom_range(100_000, 50_000_000));
    r_chip[i]  = 1'($urandom);
    r_cpol[i]  = 1'($urandom);
    r_cpha[i]  = 1'($urandom);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int d = 0; d < NREQ; d++) if (v[(p + d) % NREQ]) return (p + d) % NREQ;
    return 0;
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {pulse1, pulse2}, 0);
    check_eq("rst_speed", speed, 1_000_000);
    check_eq("rst_data2send", data2send, 0);
    check_eq("rst_mode", {cpol, cpha}, 0);
    check_eq("rst_resp_data", resp_data, 0);
  endtask

  task automatic xfer(input bit mutate, input bit add, input bit rst_mid);
    int g;
    logic [7:0] e_data;
    logic [SPEED_W-1:0] e_speed;
    logic e_chip, e_cpol, e_cpha;
    bit got, arm;
    @(negedge clk); drive(); #1;
    g = pick(pend, ptr);
    check_eq("grant", req_ready, 64'(1) << g);
    check_eq("busy_grant", busy, 1);
    e_data = r_data[g]; e_speed = r_speed[g];
    e_chip = r_chip[g]; e_cpol = r_cpol[g]; e_cpha = r_cpha[g];
    pend[g] = 1'b0;
    ptr = (g + 1) % NREQ;
    @(negedge clk); if (mutate) new_cfg(g); drive(); #1;
    check_eq("pulse1", pulse1, !e_chip);
    check_eq("pulse2", pulse2, e_chip);
    check_eq("cfg_launch", {speed, data2send, cpol, cpha}, {e_speed, e_data, e_cpol, e_cpha});
    got = 0; arm = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (arm) begin
        reset = 1'b1; pend = '0; drive(); #1;
        check_reset_vals();
        @(negedge clk); @(negedge clk); reset = 1'b0; ptr = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk); #1;
          check_eq("post_rst_resp", resp_valid, 0);
          check_eq("post_rst_busy", busy, 0);
        end
        return;
      end
      if (mutate) new_cfg(g);
      if (add && $urandom_range(0, 7) == 0) begin
        int k = $urandom_range(0, NREQ - 1);
        if (!pend[k]) begin new_cfg(k); pend[k] = 1'b1; end
      end
      drive(); #1;
      check_eq("cfg_hold", {speed, data2send, cpol, cpha}, {e_speed, e_data, e_cpol, e_cpha});
      check_eq("ready_busy", req_ready, 0);
      check_eq("busy_xfer", busy, 1);
      if (rst_mid && m_phase == 2) arm = 1;
      if (resp_valid != '0) begin
        got = 1;
        check_eq("resp_valid", resp_valid, 64'(1) << g);
        check_eq("resp_data", resp_data, e_data);
        check_eq("resp_err", resp_err, 0);
        check_eq("resp_latency", cyc - rise_cyc, 1);
      end
    end
    check_eq("resp_seen", got, 1);
  endtask

  initial begin
    int t0;
    bit got;
    reset = 1'b1; pend = '0;
    for (int i = 0; i < NREQ; i++) new_cfg(i);
    drive();
    @(negedge clk); #1;
    check_reset_vals();
    @(negedge clk); reset = 1'b0;

    r_data[0] = 8'hA5; r_chip[0] = 0; r_speed[0] = 1_000_000; r_cpol[0] = 0; r_cpha[0] = 0;
    pend = 'b001; xfer(0, 0, 0);
    r_data[1] = 8'h3C; r_chip[1] = 1; r_speed[1] = 2_000_000; r_cpol[1] = 0; r_cpha[1] = 1;
    pend = 'b010; xfer(0, 0, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) begin new_cfg(i); pend[i] = 1'b1; end
      xfer(1, 0, 0);
    end

    if (pend == '0) pend[NREQ-1] = 1'b1;
    xfer(0, 0, 1);
    pend = '0; pend[0] = 1'b1; new_cfg(0);
    xfer(0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      if (pend == '0) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          @(negedge clk); drive(); #1;
          check_eq("idle_busy", busy, 0);
          check_eq("idle_ready", req_ready, 0);
        end
        pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) if (pend[i]) new_cfg(i);
      end
      xfer(1'($urandom), 1, 0);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    while (pend != '0) xfer(0, 0, 0);
    stuck = 1; new_cfg(0); r_chip[0] = 1'b0; pend[0] = 1'b1;
    @(negedge clk); drive(); #1;
    check_eq("tmo_grant", req_ready, 64'(1) << pick(pend, ptr));
    ptr = (pick(pend, ptr) + 1) % NREQ; pend = '0; t0 = cyc; got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk); drive(); #1;
      if (resp_valid != '0) begin
        got = 1;
        check_eq("tmo_resp_valid", resp_valid, 1);
        check_eq("tmo_resp_err", resp_err, 1);
        check_eq("tmo_resp_data", resp_data, 8'hFF);
        check_eq("tmo_latency", cyc - t0, TMO + 2);
      end
    end
    check_eq("tmo_seen", got, 1);
    @(negedge clk); #1;
    check_eq("tmo_idle", busy, 0);
    stuck = 0;
`else
    t0 = 0; got = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1, "watchdog");
  end

endmodule
